nor_stim_seq: RTL
=================

Name: nor_stim_seq

Overview:
- Synchronous stimulus sequencer feeding the four inputs (ina, inb, inc, ind) of the 4-input NOR block.
- Replaces free-running delay-based toggling with a clocked, programmable vector source.
- Emits NUM_VEC vectors in one of four pattern modes, each held for a programmable number of cycles.
- Provides start/busy/done handshake and a valid strobe for a downstream checker.

Parameters:
- NUM_VEC, 16, vectors per run; legal range 1..16.
- HOLD_W, 8, width of the hold-count input.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  one-cycle run request; sampled only in IDLE.
- mode  input  2  pattern select; latched on accepted start.
- hold  input  HOLD_W  cycles each vector is held; latched on accepted start; 0 treated as 1.
- ina  output  1  NOR input a, bit 3 of current vector.
- inb  output  1  NOR input b, bit 2.
- inc  output  1  NOR input c, bit 1.
- ind  output  1  NOR input d, bit 0.
- valid  output  1  high while ina..ind carry a sequenced vector.
- vec_idx  output  4  index of current vector, 0..NUM_VEC-1.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse at end of run.

Behaviour:
- Reset: synchronous, active-low, sampled on rising clk; reset is synchronous and active-low.
- Reset values: state=IDLE; ina/inb/inc/ind=0; valid=0; vec_idx=0; busy=0; done=0; hold counter=0.
- Reset mid-RUN: abort immediately, same values, no done pulse.
- States: IDLE, RUN, DONE.
- IDLE -> RUN on start=1:
  - latch mode and hold, with hold=0 latched as 1.
  - Next cycle: vec_idx=0, vector 0 on outputs, valid=1, busy=1.
- RUN:
  - Hold counter counts 1..H, where H is the latched hold.
  - Outputs stay stable for exactly H cycles per vector.
  - After H cycles: vec_idx+1 and next vector, no gap cycle.
  - After the last vector (vec_idx=NUM_VEC-1) has been held H cycles: go to DONE.
- DONE (one cycle):
  - done=1; busy=0; valid=0; ina..ind=0; vec_idx=0.
  - Then -> IDLE.
- Start handling: start in RUN or DONE is ignored, not queued. mode and hold changes during RUN have no effect.
- Run length: total cycles from start accepted to done = NUM_VEC*H + 1.
- Vector v(i) for index i, mapped as {ina,inb,inc,ind} = v[3:0]:
  - mode 00 binary: v = i.
  - mode 01 Gray: v = i ^ (i>>1).
  - mode 10 toggle chain:
    - v(0)=0000; step i toggles bit 3-((i-1) mod 4), i.e. a, b, c, d in turn.
    - Sequence: 0000, 1000, 1100, 1110, 1111, 0111, 0011, 0001, 0000, ... period 8.
  - mode 11 walking one: v = 1000 >> (i mod 4).
- Width rules:
  - Hold counter is HOLD_W bits; max hold 2^HOLD_W-1 with no overflow.
  - vec_idx is 4 bits; NUM_VEC=16 wraps naturally to 0 only at DONE.
- NUM_VEC=1: a single vector held H cycles, then DONE.

Test Plan:
- Reset, then idle 5 cycles -> all outputs 0, busy=0, done=0. Assert rst_n=0 any cycle -> same values next edge.
- mode=00, hold=1, start -> vectors 0000..1111 on consecutive cycles, valid=1 for 16 cycles. done pulses on cycle 17 after start.
- mode=01, hold=3 -> each Gray vector (0000, 0001, 0011, 0010, ...) held 3 cycles. done at cycle 49; busy high 48 cycles.
- mode=10, hold=0 (treated as 1) -> 0000, 1000, 1100, 1110, 1111, 0111, 0011, 0001, repeated twice. Extra start pulses mid-run are ignored.
- mode=11, hold=2, with mode changed to 00 mid-run -> walking-one 1000, 0100, 0010, 0001 persists all 16 vectors, each held 2 cycles.
- rst_n=0 at vec_idx=7 during a hold=4 run -> next cycle IDLE with outputs 0 and no done. A fresh start restarts at vec_idx=0.

Source files
------------

// File: rtl/nor_stim_seq.sv
// nor_stim_seq
// Clocked, programmable stimulus source for the four inputs of a 4-input NOR
// block. A run emits NUM_VEC vectors in one of four pattern modes. Each vector
// is held for a latched number of cycles. A start/busy/done handshake and a
// valid strobe let a downstream checker follow the run.
// Vector bits map as {ina, inb, inc, ind} = vec[3:0].

module nor_stim_seq #(
  parameter int NUM_VEC = 16,  // vectors per run, legal range 1..16
  parameter int HOLD_W  = 8    // width of the hold-count input
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [HOLD_W-1:0] hold,
  output logic              ina,
  output logic              inb,
  output logic              inc,
  output logic              ind,
  output logic              valid,
  output logic [3:0]        vec_idx,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    PAT_BINARY = 2'd0,
    PAT_GRAY   = 2'd1,
    PAT_TOGGLE = 2'd2,
    PAT_WALK   = 2'd3
  } pat_e;

  // The index of the final vector. With NUM_VEC=16 this is 4'hF, so the
  // 4-bit index never has to hold NUM_VEC itself.
  localparam logic [3:0]        LAST_IDX = 4'(NUM_VEC - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_ZERO = '0;

  // Maps a vector index to its pattern for the selected mode.
  function automatic logic [3:0] pattern_vec(input pat_e pat, input logic [3:0] idx);
    logic [3:0] v;
    v = 4'b0000;
    case (pat)
      PAT_BINARY: v = idx;
      PAT_GRAY:   v = idx ^ (idx >> 1);
      // Toggle chain flips a, b, c, d in turn. This is a 4-bit Johnson
      // sequence with period 8, so only the low three index bits matter.
      PAT_TOGGLE: begin
        case (idx[2:0])
          3'd0: v = 4'b0000;
          3'd1: v = 4'b1000;
          3'd2: v = 4'b1100;
          3'd3: v = 4'b1110;
          3'd4: v = 4'b1111;
          3'd5: v = 4'b0111;
          3'd6: v = 4'b0011;
          3'd7: v = 4'b0001;
          default: v = 4'b0000;
        endcase
      end
      PAT_WALK:   v = 4'b1000 >> idx[1:0];
      default:    v = 4'b0000;
    endcase
    return v;
  endfunction

  state_e            state_q;
  pat_e              mode_q;
  logic [HOLD_W-1:0] hold_q;      // latched hold, never zero while in RUN
  logic [HOLD_W-1:0] hold_cnt_q;  // counts 1..hold_q for the current vector
  logic [3:0]        idx_q;
  logic [3:0]        vec_q;
  logic              valid_q;
  logic              busy_q;
  logic              done_q;

  logic [HOLD_W-1:0] hold_d;      // hold value captured on an accepted start
  logic [3:0]        vec0_d;      // first vector for the requested mode
  logic [3:0]        idx_d;       // index of the following vector
  logic [3:0]        vec_d;       // following vector for the latched mode
  logic [HOLD_W-1:0] hold_cnt_d;  // hold counter advanced by one
  logic              hold_end;    // current vector has been held long enough
  logic              last_vec;    // current vector is the final one of the run

  // Next-value terms shared by the state machine.
  always_comb begin
    // NOTE: every signal gets a value before any branch, so no path through
    // this block can leave a signal unassigned and infer a latch.
    hold_d     = hold;
    vec0_d     = pattern_vec(pat_e'(mode), 4'd0);
    idx_d      = idx_q + 4'd1;
    vec_d      = pattern_vec(mode_q, idx_d);
    hold_cnt_d = hold_cnt_q + HOLD_ONE;
    hold_end   = (hold_cnt_q == hold_q);
    last_vec   = (idx_q == LAST_IDX);
    // A zero hold would never end a vector, so it is run as a hold of one.
    if (hold == HOLD_ZERO) hold_d = HOLD_ONE;
  end

  // Sequencer state machine. All outputs are registered here.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments, so every
    // right-hand side reads the value from before this clock edge.
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      mode_q     <= PAT_BINARY;
      hold_q     <= HOLD_ONE;
      hold_cnt_q <= HOLD_ZERO;
      idx_q      <= 4'd0;
      vec_q      <= 4'd0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q    <= ST_RUN;
            mode_q     <= pat_e'(mode);
            hold_q     <= hold_d;
            hold_cnt_q <= HOLD_ONE;
            idx_q      <= 4'd0;
            vec_q      <= vec0_d;
            valid_q    <= 1'b1;
            busy_q     <= 1'b1;
          end
        end

        ST_RUN: begin
          if (hold_end) begin
            if (last_vec) begin
              state_q    <= ST_DONE;
              hold_cnt_q <= HOLD_ZERO;
              idx_q      <= 4'd0;
              vec_q      <= 4'd0;
              valid_q    <= 1'b0;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
            end else begin
              // Step straight to the next vector with no gap cycle.
              hold_cnt_q <= HOLD_ONE;
              idx_q      <= idx_d;
              vec_q      <= vec_d;
            end
          end else begin
            // Stops at hold_q, so even a hold of 2^HOLD_W-1 cannot overflow.
            hold_cnt_q <= hold_cnt_d;
          end
        end

        ST_DONE: begin
          // Stays for one cycle only. A start seen here is dropped.
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
        end

        default: begin
          state_q    <= ST_IDLE;
          hold_cnt_q <= HOLD_ZERO;
          idx_q      <= 4'd0;
          vec_q      <= 4'd0;
          valid_q    <= 1'b0;
          busy_q     <= 1'b0;
          done_q     <= 1'b0;
        end
      endcase
    end
  end

  assign ina     = vec_q[3];
  assign inb     = vec_q[2];
  assign inc     = vec_q[1];
  assign ind     = vec_q[0];
  assign valid   = valid_q;
  assign vec_idx = idx_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule
